// File: rtl/dirty_dump_pkg.sv
// Shared types and defaults for the dirty-word dump controller.
package dirty_dump_pkg;

  localparam int unsigned N_ELEMENTS_DEF = 128;
  localparam int unsigned DATA_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_READ = 3'd2,
    ST_WAIT = 3'd3,
    ST_SEND = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // Word-address width for a memory of n words (at least one bit).
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dirty_dump_ctrl_find_first_set.sv
// Combinational lowest-set-bit priority encoder.
module find_first_set
  import dirty_dump_pkg::*;
#(
  parameter int unsigned N_ELEMENTS = N_ELEMENTS_DEF,
  parameter int unsigned ADDR_WIDTH = addr_width(N_ELEMENTS)
) (
  input  logic [N_ELEMENTS-1:0] vec_i,
  output logic [ADDR_WIDTH-1:0] index_o,
  output logic                  found_o
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    index_o = '0;
    found_o = 1'b0;
    for (int i = int'(N_ELEMENTS) - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        index_o = ADDR_WIDTH'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dirty_dump_ctrl.sv
// Walks a snapshot of the dirty-bit vector and streams each dirty word
// out as an (address, data) pair to the debug transmit path.
module dirty_dump_ctrl
  import dirty_dump_pkg::*;
#(
  parameter int unsigned N_ELEMENTS = N_ELEMENTS_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = addr_width(N_ELEMENTS)
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [N_ELEMENTS-1:0] dirty_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_rd_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic [ADDR_WIDTH-1:0] tx_addr_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH:0]   count_o
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  state_e                r_state,    w_state_nxt;
  logic [N_ELEMENTS-1:0] r_snap,     w_snap_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic                  r_mem_rd,   w_mem_rd_nxt;
  logic                  r_tx_valid, w_tx_valid_nxt;
  logic [ADDR_WIDTH-1:0] r_tx_addr,  w_tx_addr_nxt;
  logic [DATA_WIDTH-1:0] r_tx_data,  w_tx_data_nxt;
  logic                  r_busy,     w_busy_nxt;
  logic                  r_done,     w_done_nxt;
  logic [CNT_W-1:0]      r_count,    w_count_nxt;

  logic [ADDR_WIDTH-1:0] w_ffs_idx;
  logic                  w_ffs_found;

  find_first_set #(
    .N_ELEMENTS (N_ELEMENTS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ffs (
    .vec_i   (r_snap),
    .index_o (w_ffs_idx),
    .found_o (w_ffs_found)
  );

  // State and registered outputs.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      r_state    <= ST_IDLE;
      r_snap     <= '0;
      r_mem_addr <= '0;
      r_mem_rd   <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_addr  <= '0;
      r_tx_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_snap     <= w_snap_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_mem_rd   <= w_mem_rd_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_addr  <= w_tx_addr_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_count    <= w_count_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_snap_nxt     = r_snap;
    w_mem_addr_nxt = r_mem_addr;
    w_mem_rd_nxt   = r_mem_rd;
    w_tx_valid_nxt = r_tx_valid;
    w_tx_addr_nxt  = r_tx_addr;
    w_tx_data_nxt  = r_tx_data;
    w_count_nxt    = r_count;

    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_snap_nxt  = dirty_i;
          w_count_nxt = '0;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (w_ffs_found) begin
          w_mem_addr_nxt = w_ffs_idx;
          w_tx_addr_nxt  = w_ffs_idx;
          w_mem_rd_nxt   = 1'b1;
          w_state_nxt    = ST_READ;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_READ: begin
        w_mem_rd_nxt = 1'b0;
        w_state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        w_tx_data_nxt  = mem_data_i;
        w_tx_valid_nxt = 1'b1;
        w_state_nxt    = ST_SEND;
      end
      ST_SEND: begin
        // tx_addr_o still holds the index of the word being sent.
        if (tx_ready_i) begin
          w_tx_valid_nxt        = 1'b0;
          w_snap_nxt[r_tx_addr] = 1'b0;
          w_count_nxt           = r_count + CNT_W'(1);
          w_state_nxt           = ST_SCAN;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  assign mem_addr_o = r_mem_addr;
  assign mem_rd_o   = r_mem_rd;
  assign tx_valid_o = r_tx_valid;
  assign tx_addr_o  = r_tx_addr;
  assign tx_data_o  = r_tx_data;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign count_o    = r_count;

endmodule

// File: tb/tb_dirty_dump_ctrl.sv
// Directed self-checking bench for dirty_dump_ctrl.
module tb_dirty_dump_ctrl;

  localparam int unsigned N  = 128;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 7;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_i = 1'b0;
  logic [N-1:0]  dirty_i = '0;
  logic [AW-1:0] mem_addr_o;
  logic          mem_rd_o;
  logic [DW-1:0] mem_data_i = '0;
  logic          tx_valid_o;
  logic          tx_ready_i = 1'b1;
  logic [AW-1:0] tx_addr_o;
  logic [DW-1:0] tx_data_o;
  logic          busy_o;
  logic          done_o;
  logic [AW:0]   count_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_data[$];
  int            got_cyc[$];
  int            done_cyc;
  int            rd_count;
  int            rd_in_stall;
  int            stable_bad;
  int            held_cycles;

  dirty_dump_ctrl u_dut (
    .clock_i    (clk),
    .reset_i    (reset_n),
    .start_i    (start_i),
    .dirty_i    (dirty_i),
    .mem_addr_o (mem_addr_o),
    .mem_rd_o   (mem_rd_o),
    .mem_data_i (mem_data_i),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .tx_addr_o  (tx_addr_o),
    .tx_data_o  (tx_data_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .count_o    (count_o)
  );

  always #5 clk = ~clk;

  // Memory model: word at address a holds a*3, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_o) mem_data_i <= {25'd0, mem_addr_o} * 32'd3;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a dump and watch it; k counts edges after the start-sampling edge.
  // stall: cycles tx_ready_i stays low at the first pair.
  // late_k: sample at which dirty_i is replaced and start_i is pulsed again.
  task automatic run_dump(input int budget, input int stall,
                          input logic [N-1:0] late_dirty, input int late_k);
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    done_cyc    = -1;
    rd_count    = 0;
    rd_in_stall = 0;
    stable_bad  = 0;
    held_cycles = 0;
    a0 = '0;
    d0 = '0;
    tx_ready_i = (stall == 0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 0; k < budget && done_cyc < 0; k++) begin
      if (k == late_k) begin
        dirty_i = late_dirty;
        start_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      if (mem_rd_o) rd_count++;
      if (done_o) done_cyc = k;
      if (tx_valid_o && !tx_ready_i) begin
        if (held_cycles == 0) begin
          a0 = tx_addr_o;
          d0 = tx_data_o;
        end else if (tx_addr_o !== a0 || tx_data_o !== d0) begin
          stable_bad++;
        end
        if (mem_rd_o) rd_in_stall++;
        held_cycles++;
        if (held_cycles >= stall) tx_ready_i = 1'b1;
      end
      if (tx_valid_o && tx_ready_i) begin
        got_addr.push_back(tx_addr_o);
        got_data.push_back(tx_data_o);
        got_cyc.push_back(k);
      end
      if (done_cyc < 0) step();
    end
    start_i = 1'b0;
    check("dump_finished", 64'(done_cyc >= 0), 64'd1);
  endtask

  initial begin
    logic [N-1:0] v;

    // Power-on reset.
    reset_n = 1'b0;
    step();
    step();
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_valid", 64'(tx_valid_o), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_memrd", 64'(mem_rd_o), 64'd0);
    reset_n = 1'b1;
    step();

    // Empty snapshot.
    dirty_i = '0;
    run_dump(50, 0, '0, -1);
    check("empty_done_cyc", 64'(done_cyc), 64'd1);
    check("empty_rd", 64'(rd_count), 64'd0);
    check("empty_pairs", 64'(got_addr.size()), 64'd0);
    check("empty_count", 64'(count_o), 64'd0);
    check("empty_busy_at_done", 64'(busy_o), 64'd1);
    step();
    check("empty_busy_after", 64'(busy_o), 64'd0);
    check("empty_done_pulse", 64'(done_o), 64'd0);

    // Sparse {0,5,127}, ready held high.
    v = '0; v[0] = 1'b1; v[5] = 1'b1; v[127] = 1'b1;
    dirty_i = v;
    run_dump(100, 0, '0, -1);
    check("sparse_pairs", 64'(got_addr.size()), 64'd3);
    if (got_addr.size() == 3) begin
      check("sparse_a0", 64'(got_addr[0]), 64'd0);
      check("sparse_d0", 64'(got_data[0]), 64'd0);
      check("sparse_c0", 64'(got_cyc[0]), 64'd3);
      check("sparse_a1", 64'(got_addr[1]), 64'd5);
      check("sparse_d1", 64'(got_data[1]), 64'd15);
      check("sparse_c1", 64'(got_cyc[1]), 64'd7);
      check("sparse_a2", 64'(got_addr[2]), 64'd127);
      check("sparse_d2", 64'(got_data[2]), 64'd381);
      check("sparse_c2", 64'(got_cyc[2]), 64'd11);
    end
    check("sparse_done_cyc", 64'(done_cyc), 64'd13);
    check("sparse_rd", 64'(rd_count), 64'd3);
    check("sparse_count", 64'(count_o), 64'd3);
    step();
    check("sparse_count_hold", 64'(count_o), 64'd3);

    // Backpressure: dirty {2,3}, ready low for the first pair.
    v = '0; v[2] = 1'b1; v[3] = 1'b1;
    dirty_i = v;
    run_dump(100, 10, '0, -1);
    check("bp_held", 64'(held_cycles), 64'd10);
    check("bp_stable", 64'(stable_bad), 64'd0);
    check("bp_no_rd_while_held", 64'(rd_in_stall), 64'd0);
    check("bp_pairs", 64'(got_addr.size()), 64'd2);
    if (got_addr.size() == 2) begin
      check("bp_a0", 64'(got_addr[0]), 64'd2);
      check("bp_d0", 64'(got_data[0]), 64'd6);
      check("bp_c0", 64'(got_cyc[0]), 64'd12);
      check("bp_a1", 64'(got_addr[1]), 64'd3);
      check("bp_d1", 64'(got_data[1]), 64'd9);
      check("bp_c1", 64'(got_cyc[1]), 64'd16);
    end
    check("bp_done_cyc", 64'(done_cyc), 64'd18);
    check("bp_count", 64'(count_o), 64'd2);
    step();

    // Snapshot isolation: dirty bit 4 and a start pulse arrive mid-dump.
    v = '0; v[1] = 1'b1;
    dirty_i = v;
    v[4] = 1'b1;
    run_dump(100, 0, v, 2);
    check("iso_pairs", 64'(got_addr.size()), 64'd1);
    if (got_addr.size() == 1) begin
      check("iso_a0", 64'(got_addr[0]), 64'd1);
      check("iso_d0", 64'(got_data[0]), 64'd3);
    end
    check("iso_done_cyc", 64'(done_cyc), 64'd5);
    check("iso_count", 64'(count_o), 64'd1);
    step();
    step();
    step();
    check("iso_no_restart", 64'(busy_o), 64'd0);
    check("iso_no_rd", 64'(mem_rd_o), 64'd0);

    // Reset asserted while a pair is waiting in SEND.
    v = '0; v[2] = 1'b1;
    dirty_i = v;
    tx_ready_i = 1'b0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    step();
    step();
    check("mid_valid_before_rst", 64'(tx_valid_o), 64'd1);
    reset_n = 1'b0;
    step();
    step();
    check("mid_rst_valid", 64'(tx_valid_o), 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_addr", 64'(tx_addr_o), 64'd0);
    check("mid_rst_data", 64'(tx_data_o), 64'd0);
    check("mid_rst_memaddr", 64'(mem_addr_o), 64'd0);
    check("mid_rst_count", 64'(count_o), 64'd0);
    reset_n = 1'b1;
    tx_ready_i = 1'b1;
    step();
    v = '0; v[9] = 1'b1;
    dirty_i = v;
    run_dump(100, 0, '0, -1);
    check("post_rst_pairs", 64'(got_addr.size()), 64'd1);
    if (got_addr.size() == 1) check("post_rst_a0", 64'(got_addr[0]), 64'd9);
    check("post_rst_count", 64'(count_o), 64'd1);
    step();

    // Full vector.
    dirty_i = '1;
    run_dump(700, 0, '0, -1);
    check("full_pairs", 64'(got_addr.size()), 64'd128);
    if (got_addr.size() == 128) begin
      for (int i = 0; i < 128; i++) begin
        check("full_addr", 64'(got_addr[i]), 64'(i));
        check("full_data", 64'(got_data[i]), 64'(i * 3));
      end
    end
    check("full_done_cyc", 64'(done_cyc), 64'd513);
    check("full_count", 64'(count_o), 64'd128);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dirty_dump_ctrl.md
# dirty_dump_ctrl

Debug-side controller that, on request, walks the data memory's dirty-bit vector and streams every dirty word out as an (address, data) pair to the debug unit's transmit path. It sits between the dirty-bit tracker, the data memory's debug read port, and the debug UART framer. It is used while the processor is halted so the host receives only modified memory locations.

## Interface
- N_ELEMENTS, 128, number of data memory words / dirty bits
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, $clog2(N_ELEMENTS), word address width
- clock_i  in  1  single clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-low reset
- start_i  in  1  dump request; sampled only in IDLE
- dirty_i  in  N_ELEMENTS  dirty-bit vector from the tracker
- mem_addr_o  out  ADDR_WIDTH  debug read address to data memory
- mem_rd_o  out  1  debug read enable, one cycle per word
- mem_data_i  in  DATA_WIDTH  read data, valid the cycle after mem_rd_o
- tx_valid_o  out  1  (addr, data) pair available
- tx_ready_i  in  1  debug unit accepts pair
- tx_addr_o  out  ADDR_WIDTH  address of pair
- tx_data_o  out  DATA_WIDTH  data of pair
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse at end of dump
- count_o  out  ADDR_WIDTH+1  words sent in current/last dump

## Operation
- States: IDLE, SCAN, READ, WAIT, SEND, DONE. All outputs registered.
- IDLE: start_i=1 → latch snapshot <= dirty_i, count_o <= 0, go SCAN. start_i ignored in all other states.
- SCAN: find lowest set bit of snapshot. None → DONE. Found idx → mem_addr_o <= idx, tx_addr_o <= idx, mem_rd_o <= 1, go READ.
- READ: mem_rd_o high this cycle; mem_rd_o <= 0, go WAIT.
- WAIT: tx_data_o <= mem_data_i, tx_valid_o <= 1, go SEND.
- SEND: hold tx_valid_o, tx_addr_o, tx_data_o stable until tx_ready_i=1. On handshake: tx_valid_o <= 0, clear snapshot[idx], count_o += 1, go SCAN.
- DONE: done_o high one cycle, go IDLE. count_o retains its value until the next start.
- dirty_i changes during a dump are ignored; only the snapshot is used. Snapshot is never written back to the tracker.
- count_o width allows full N_ELEMENTS (128 → 8 bits); no wrap is possible.
- Reset (reset_i=0 at an edge, any state): state IDLE, snapshot 0, count_o 0, all outputs 0. An in-flight pair is dropped and tx_valid_o deasserts the next cycle.

## Timing
- start sampled at edge E0. SCAN occupies cycle E0→E1. mem_rd_o is high E1→E2. WAIT is E2→E3. tx_valid_o first high from E3.
- Per word with tx_ready_i held high: 4 cycles (SCAN, READ, WAIT, SEND).
- Empty snapshot: SCAN at cycle 1, done_o high cycle 2 after start, busy_o low cycle 3.
- N dirty words with ready held high: done_o asserted 4N+1 cycles after the SCAN entry.
- tx_valid_o never drops without a handshake except on reset. mem_rd_o is never high outside READ.

## Structure
- Package dirty_dump_pkg: state enum (6 states, 3-bit encoding), default N_ELEMENTS/DATA_WIDTH constants, ADDR_WIDTH function.
- Sub-module find_first_set: combinational lowest-set-bit priority encoder over N_ELEMENTS. Outputs index (ADDR_WIDTH) and found (1). Instantiated once on the snapshot.

## Test plan
- Reset: hold reset_i=0 two cycles mid-SEND → all outputs 0, busy_o=0, next start works normally.
- Empty: dirty_i=0, start pulse → no mem_rd_o, done_o pulse 2 cycles after start, count_o=0.
- Sparse: dirty bits {0,5,127}, memory word = addr×3, ready always 1 → pairs (0,0),(5,15),(127,381) in order, 4 cycles apart, count_o=3.
- Backpressure: dirty {2,3}, tx_ready_i low 10 cycles at first pair → tx_valid_o/tx_addr_o=2/tx_data_o held stable 10 cycles, no second mem_rd_o until handshake.
- Snapshot isolation: start with dirty {1}, set dirty bit 4 mid-dump; also pulse start_i while busy → only addr 1 sent, count_o=1, no restart.
- Full: all 128 bits set, ready=1 → 128 pairs addr 0..127, count_o=128, done_o 513 cycles after the SCAN entry.
